// File: rtl/auto_opponent_if.sv
// Board-side signal bundle between the automated human player and the
// computer game: the board displays and win flag flow to the player, and
// the chosen move plus button presses flow back to the game.
interface auto_opponent_if;
  logic [3:0] c3, c2, c1, c0;
  logic [3:0] h3, h2, h1, h0;
  logic       win;
  logic [3:0] hMove;
  logic       enter_L;
  logic       newGame_L;

  modport master (
    input  c3, c2, c1, c0, h3, h2, h1, h0, win,
    output hMove, enter_L, newGame_L
  );

  modport slave (
    output c3, c2, c1, c0, h3, h2, h1, h0, win,
    input  hMove, enter_L, newGame_L
  );
endinterface

// File: rtl/auto_opponent.sv
// Automated human-side player for the pick-15 game. Watches the computer's
// board, picks a winning, blocking or lowest free digit, presses enter,
// waits for the move to show up, and tallies game results.
module auto_opponent #(
  parameter int PRESS_CYCLES  = 2,
  parameter int ACK_TIMEOUT   = 15,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  auto_opponent_if.master board,
  output logic       busy,
  output logic       error,
  output logic [7:0] games,
  output logic [7:0] losses,
  output logic [7:0] hwins
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] WAIT_C  = 4'd1;
  localparam logic [3:0] CHOOSE  = 4'd2;
  localparam logic [3:0] PRESS   = 4'd3;
  localparam logic [3:0] ACK     = 4'd4;
  localparam logic [3:0] CHECK   = 4'd5;
  localparam logic [3:0] SETTLE  = 4'd6;
  localparam logic [3:0] OVER    = 4'd7;
  localparam logic [3:0] NEWGAME = 4'd8;
  localparam logic [3:0] ERROR   = 4'd9;

  localparam logic [15:0] PRESS_LAST  = 16'(PRESS_CYCLES - 1);
  localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  logic [3:0]  state;
  logic [15:0] cnt;
  logic [2:0]  nhSaved;
  logic        waitClear;

  logic [15:0] cDigits, hDigits;
  logic [2:0]  nc, nh;
  logic [9:0]  usedMask, freeMask;
  logic [3:0]  winPick, blockPick, anyPick, choice;
  logic        hTriple, moveSeen;

  // Bit x set when x would complete some pair of nonzero digits to 15.
  function automatic logic [9:0] completeMask(input logic [15:0] d);
    logic [9:0] m;
    logic [4:0] s;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        s = {1'b0, d[4*i +: 4]} + {1'b0, d[4*j +: 4]};
        if (d[4*i +: 4] != 4'd0 && d[4*j +: 4] != 4'd0 &&
            s >= 5'd6 && s <= 5'd14)
          m[4'(5'd15 - s)] = 1'b1;
      end
    end
    return m;
  endfunction

  // True when any three nonzero digits sum to 15.
  function automatic logic tripleOf(input logic [15:0] d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        for (int k = j + 1; k < 4; k++)
          if (d[4*i +: 4] != 4'd0 && d[4*j +: 4] != 4'd0 && d[4*k +: 4] != 4'd0 &&
              ({2'b0, d[4*i +: 4]} + {2'b0, d[4*j +: 4]} + {2'b0, d[4*k +: 4]}) == 6'd15)
            r = 1'b1;
    return r;
  endfunction

  // Smallest digit 1..9 whose bit is set, or 0 when none is.
  function automatic logic [3:0] lowestBit(input logic [9:0] m);
    logic [3:0] r;
    r = '0;
    for (int x = 9; x >= 1; x--)
      if (m[x]) r = 4'(x);
    return r;
  endfunction

  assign cDigits = {board.c3, board.c2, board.c1, board.c0};
  assign hDigits = {board.h3, board.h2, board.h1, board.h0};

  // Board census and move selection, recomputed every cycle from the displays.
  always_comb begin
    nc       = '0;
    nh       = '0;
    usedMask = '0;
    moveSeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cDigits[4*i +: 4] != 4'd0) begin
        nc = nc + 3'd1;
        if (cDigits[4*i +: 4] <= 4'd9) usedMask[cDigits[4*i +: 4]] = 1'b1;
      end
      if (hDigits[4*i +: 4] != 4'd0) begin
        nh = nh + 3'd1;
        if (hDigits[4*i +: 4] <= 4'd9) usedMask[hDigits[4*i +: 4]] = 1'b1;
      end
      if (board.hMove != 4'd0 && hDigits[4*i +: 4] == board.hMove) moveSeen = 1'b1;
    end
    freeMask  = ~usedMask & 10'h3FE;
    winPick   = lowestBit(completeMask(hDigits) & freeMask);
    blockPick = lowestBit(completeMask(cDigits) & freeMask);
    anyPick   = lowestBit(freeMask);
    if (winPick != 4'd0)        choice = winPick;
    else if (blockPick != 4'd0) choice = blockPick;
    else                        choice = anyPick;
    hTriple = tripleOf(hDigits);
  end

  assign busy = (state != IDLE) && (state != ERROR);

  // Game-playing sequencer: move choice, button timing, result counting.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state           <= IDLE;
      cnt             <= '0;
      nhSaved         <= '0;
      waitClear       <= 1'b0;
      board.hMove     <= '0;
      board.enter_L   <= 1'b1;
      board.newGame_L <= 1'b1;
      error           <= 1'b0;
      games           <= '0;
      losses          <= '0;
      hwins           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !error) state <= WAIT_C;
        end
        WAIT_C: begin
          if (waitClear) begin
            if (nc == 3'd1 && nh == 3'd0 && !board.win) waitClear <= 1'b0;
          end else if (board.win) begin
            state <= OVER;
          end else if (nh == 3'd4) begin
            cnt   <= '0;
            state <= SETTLE;
          end else if (nc == nh + 3'd1) begin
            state <= CHOOSE;
          end
        end
        CHOOSE: begin
          if (choice == 4'd0) begin
            state <= OVER;
          end else begin
            board.hMove   <= choice;
            nhSaved       <= nh;
            board.enter_L <= 1'b0;
            cnt           <= '0;
            state         <= PRESS;
          end
        end
        PRESS: begin
          if (cnt == PRESS_LAST) begin
            board.enter_L <= 1'b1;
            cnt           <= '0;
            state         <= ACK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACK: begin
          if (nh > nhSaved && moveSeen) begin
            state <= CHECK;
          end else if (cnt == ACK_LAST) begin
            error       <= 1'b1;
            board.hMove <= '0;
            state       <= ERROR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CHECK: begin
          state <= hTriple ? OVER : WAIT_C;
        end
        SETTLE: begin
          if (board.win || cnt == SETTLE_LAST) state <= OVER;
          else                                 cnt   <= cnt + 16'd1;
        end
        OVER: begin
          if (games != 8'hFF)                  games  <= games + 8'd1;
          if (board.win && losses != 8'hFF)    losses <= losses + 8'd1;
          if (hTriple && hwins != 8'hFF)       hwins  <= hwins + 8'd1;
          board.hMove     <= '0;
          board.newGame_L <= 1'b0;
          cnt             <= '0;
          state           <= NEWGAME;
        end
        NEWGAME: begin
          if (cnt == PRESS_LAST) begin
            board.newGame_L <= 1'b1;
            waitClear       <= 1'b1;
            state           <= start ? WAIT_C : IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ERROR: begin
          board.hMove     <= '0;
          board.enter_L   <= 1'b1;
          board.newGame_L <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_auto_opponent.sv
// Bench for auto_opponent: emulates the computer side of the game board and
// checks every move, press, and tally against a digit-list model of the rules.
module tb_auto_opponent;
  localparam int PRESS_CYCLES  = 2;
  localparam int ACK_TIMEOUT   = 15;
  localparam int SETTLE_CYCLES = 4;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       start;
  logic       busy, error;
  logic [7:0] games, losses, hwins;

  auto_opponent_if bus ();

  auto_opponent #(
    .PRESS_CYCLES (PRESS_CYCLES),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clock  (clock),
    .reset_L(reset_L),
    .start  (start),
    .board  (bus),
    .busy   (busy),
    .error  (error),
    .games  (games),
    .losses (losses),
    .hwins  (hwins)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  int testsRun = 0;
  int testsFailed = 0;

  int cB[5], hB[5];
  int nC, nH;
  bit winReg;
  int openDelay, ackDelay, compDelay, ackMove;
  bit ackDisabled, cheatLoss, ngSeen, inAck, envPrevEnter;
  int script[$];

  bit monEnable, prevEnter, prevNg;
  int pressCnt, ngCnt, latchedMove, gameEnds;
  int expGames, expLosses, expHwins;
  int chosen[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit inList(input int d[5], input int n, input int x);
    for (int i = 0; i < n; i++) if (d[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pairMakes(input int d[5], input int n, input int target);
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (d[i] + d[j] == target) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hasTriple(input int d[5], input int n);
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        for (int k = j + 1; k < n; k++)
          if (d[i] + d[j] + d[k] == 15) return 1'b1;
    return 1'b0;
  endfunction

  // Rules-level move choice: win, else block, else lowest free digit.
  function automatic int modelChoice(input int c[5], input int cn, input int h[5], input int hn);
    for (int x = 1; x <= 9; x++)
      if (!inList(c, cn, x) && !inList(h, hn, x) && pairMakes(h, hn, 15 - x)) return x;
    for (int x = 1; x <= 9; x++)
      if (!inList(c, cn, x) && !inList(h, hn, x) && pairMakes(c, cn, 15 - x)) return x;
    for (int x = 1; x <= 9; x++)
      if (!inList(c, cn, x) && !inList(h, hn, x)) return x;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic driveBoard();
    bus.c0  = (nC > 0) ? 4'(cB[0]) : 4'd0;
    bus.c1  = (nC > 1) ? 4'(cB[1]) : 4'd0;
    bus.c2  = (nC > 2) ? 4'(cB[2]) : 4'd0;
    bus.c3  = (nC > 3) ? 4'(cB[3]) : 4'd0;
    bus.h3  = (nH > 0) ? 4'(hB[0]) : 4'd0;
    bus.h1  = (nH > 1) ? 4'(hB[1]) : 4'd0;
    bus.h0  = (nH > 2) ? 4'(hB[2]) : 4'd0;
    bus.h2  = (nH > 3) ? 4'(hB[3]) : 4'd0;
    bus.win = winReg;
  endtask

  // The fifth computer digit has no display slot; it only matters via win.
  task automatic compMove();
    int d;
    if (script.size() > 0) d = script.pop_front();
    else begin
      d = $urandom_range(1, 9);
      while (inList(cB, nC, d) || inList(hB, nH, d)) d = $urandom_range(1, 9);
    end
    cB[nC] = d;
    nC++;
    if (hasTriple(cB, nC)) winReg = 1'b1;
  endtask

  task automatic envReset();
    nC = 0; nH = 0; winReg = 1'b0;
    openDelay = -1; ackDelay = -1; compDelay = -1; ackMove = 0;
    ngSeen = 1'b0; inAck = 1'b0; envPrevEnter = 1'b1;
    cheatLoss = 1'b0;
    script.delete();
    driveBoard();
  endtask

  task automatic monReset();
    prevEnter = 1'b1; prevNg = 1'b1;
    pressCnt = 0; ngCnt = 0; latchedMove = 0;
    expGames = 0; expLosses = 0; expHwins = 0;
  endtask

  // Per-cycle comparison of DUT outputs against the rules model.
  task automatic compareStep();
    checkOutput("exclusiveButtons", {31'd0, bus.enter_L | bus.newGame_L}, 1);
    if (bus.enter_L == 1'b0) begin
      if (prevEnter) begin
        latchedMove = modelChoice(cB, nC, hB, nH);
        checkOutput("choice", bus.hMove, latchedMove);
        chosen.push_back(int'(bus.hMove));
        pressCnt = 1;
      end else begin
        pressCnt++;
        checkOutput("pressHold", bus.hMove, latchedMove);
      end
    end else if (!prevEnter) begin
      checkOutput("pressLen", pressCnt, PRESS_CYCLES);
    end
    if (inAck && !ackDisabled) checkOutput("ackHold", bus.hMove, latchedMove);
    if (bus.newGame_L == 1'b0) begin
      if (prevNg) begin
        gameEnds++;
        expGames = sat(expGames + 1);
        if (winReg) expLosses = sat(expLosses + 1);
        if (hasTriple(hB, nH)) expHwins = sat(expHwins + 1);
        checkOutput("games", games, expGames);
        checkOutput("losses", losses, expLosses);
        checkOutput("hwins", hwins, expHwins);
        checkOutput("hMoveOver", bus.hMove, 0);
        ngCnt = 1;
      end else ngCnt++;
    end else if (!prevNg) begin
      checkOutput("newGameLen", ngCnt, PRESS_CYCLES);
    end
    if (!ackDisabled) checkOutput("noError", error, 0);
    prevEnter = bus.enter_L;
    prevNg    = bus.newGame_L;
  endtask

  // Computer-side behaviour: clears on new game, opens, acks, and replies.
  task automatic envStep();
    if (bus.newGame_L == 1'b0) begin
      nC = 0; nH = 0; winReg = 1'b0; ngSeen = 1'b1;
      ackDelay = -1; compDelay = -1; inAck = 1'b0;
    end else if (ngSeen) begin
      ngSeen = 1'b0;
      openDelay = $urandom_range(1, 3);
    end
    if (openDelay == 0) begin compMove(); openDelay = -1; end
    else if (openDelay > 0) openDelay--;
    if (bus.enter_L == 1'b1 && !envPrevEnter && !ackDisabled) begin
      ackDelay = $urandom_range(0, 5);
      ackMove  = int'(bus.hMove);
      inAck    = 1'b1;
    end
    envPrevEnter = bus.enter_L;
    if (ackDelay == 0) begin
      hB[nH] = ackMove;
      nH++;
      ackDelay = -1;
      inAck = 1'b0;
      if (!hasTriple(hB, nH)) begin
        if (cheatLoss) begin winReg = 1'b1; cheatLoss = 1'b0; end
        else if (nC < 5) compDelay = (nH == 4) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      end
    end else if (ackDelay > 0) ackDelay--;
    if (compDelay == 0) begin compMove(); compDelay = -1; end
    else if (compDelay > 0) compDelay--;
    driveBoard();
  endtask

  task automatic applyStimulus();
    @(negedge clock);
    if (monEnable) compareStep();
    #1;
    envStep();
  endtask

  task automatic waitGames(input int target, input int bound);
    int k = 0;
    while (gameEnds < target && k < bound) begin applyStimulus(); k++; end
    checkOutput($sformatf("gamesReached%0d", target), gameEnds, target);
  endtask

  task automatic waitEnterLow(input int bound);
    int k = 0;
    while (bus.enter_L !== 1'b0 && k < bound) begin applyStimulus(); k++; end
    checkOutput("enterLowSeen", {31'd0, bus.enter_L}, 0);
  endtask

  int pc[5], ph[5];
  int lowCount;

  initial begin
    reset_L = 1'b0; start = 1'b0; monEnable = 1'b0; ackDisabled = 1'b0;
    gameEnds = 0;
    envReset();
    monReset();
    repeat (3) @(negedge clock);
    checkOutput("rstHMove", bus.hMove, 0);
    checkOutput("rstEnter", bus.enter_L, 1);
    checkOutput("rstNewGame", bus.newGame_L, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstError", error, 0);
    checkOutput("rstGames", games, 0);
    checkOutput("rstLosses", losses, 0);
    checkOutput("rstHwins", hwins, 0);

    pc = '{5, 0, 0, 0, 0}; ph = '{0, 0, 0, 0, 0};
    checkOutput("modelOpen", modelChoice(pc, 1, ph, 0), 1);
    pc = '{5, 2, 0, 0, 0}; ph = '{1, 0, 0, 0, 0};
    checkOutput("modelBlock", modelChoice(pc, 2, ph, 1), 8);
    pc = '{5, 2, 4, 0, 0}; ph = '{1, 8, 0, 0, 0};
    checkOutput("modelWin", modelChoice(pc, 3, ph, 2), 6);
    pc = '{4, 9, 0, 0, 0}; ph = '{2, 0, 0, 0, 0};
    checkOutput("modelBlockOnly", modelChoice(pc, 2, ph, 1), 1);  // 4+9 -> block 2? used; lowest free 1
    ph = '{1, 8, 6, 0, 0};
    checkOutput("modelTriple", {31'd0, hasTriple(ph, 3)}, 1);

    // Scripted human-win game: picks 1, then block 8, then win 6.
    @(negedge clock); #1;
    reset_L = 1'b1;
    script.push_back(5); script.push_back(2); script.push_back(4);
    openDelay = 2;
    start = 1'b1;
    monEnable = 1'b1;
    chosen.delete();
    waitGames(1, 400);
    checkOutput("firstGameMoves", chosen.size(), 3);
    if (chosen.size() == 3) begin
      checkOutput("move1", chosen[0], 1);
      checkOutput("move2", chosen[1], 8);
      checkOutput("move3", chosen[2], 6);
    end
    checkOutput("hwinsAfterFirst", hwins, 1);
    checkOutput("gamesAfterFirst", games, 1);

    // Loss forced while waiting for the computer; start drops mid-game.
    cheatLoss = 1'b1;
    waitEnterLow(200);
    start = 1'b0;
    waitGames(2, 400);
    repeat (PRESS_CYCLES + 3) applyStimulus();
    checkOutput("idleBusy", busy, 0);
    checkOutput("lossCount", losses, 1);
    lowCount = 0;
    repeat (10) begin applyStimulus(); if (bus.enter_L == 1'b0) lowCount++; end
    checkOutput("idleNoPress", lowCount, 0);

    // Long random self-play run, long enough to saturate the game counter.
    start = 1'b1;
    waitGames(260, 40000);
    checkOutput("gamesSaturated", games, 255);

    // Reset in the middle of an enter press.
    waitEnterLow(200);
    monEnable = 1'b0;
    reset_L = 1'b0;
    #1;
    checkOutput("midRstEnter", bus.enter_L, 1);
    checkOutput("midRstHMove", bus.hMove, 0);
    checkOutput("midRstGames", games, 0);
    checkOutput("midRstBusy", busy, 0);
    start = 1'b0;
    envReset();
    monReset();
    repeat (3) @(negedge clock);
    #1;
    reset_L = 1'b1;

    // Entered move never acknowledged: sticky error, no further presses.
    ackDisabled = 1'b1;
    openDelay = 1;
    start = 1'b1;
    monEnable = 1'b1;
    begin
      int k = 0;
      while (error !== 1'b1 && k < 80) begin applyStimulus(); k++; end
    end
    checkOutput("errorSet", error, 1);
    checkOutput("errorBusy", busy, 0);
    checkOutput("errorEnter", bus.enter_L, 1);
    checkOutput("errorHMove", bus.hMove, 0);
    lowCount = 0;
    repeat (20) begin applyStimulus(); if (bus.enter_L == 1'b0) lowCount++; end
    checkOutput("errorNoPress", lowCount, 0);
    checkOutput("errorSticky", error, 1);
    start = 1'b0;
    reset_L = 1'b0;
    #1;
    checkOutput("errorCleared", error, 0);
    repeat (2) @(negedge clock);
    reset_L = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
